execute_stage: RTL and testbench
================================

Name: execute_stage

Overview:
- Third pipeline stage (EX), directly upstream of the memory-write stage.
- Takes decoded instructions and operand values from decode, performs ALU ops, address generation and branch resolution, and registers the result into the EX/MEM pipeline register.
- MUL is iterative (shift-add, one bit per cycle); the stage stalls upstream and emits NOPE bubbles downstream until the product is ready.

Parameters:
- DW, 32, data/operand width
- RW, 6, register-index field width
- IW, 16, immediate width, sign-extended to DW

Ports:
- clk_46  input  1  clock, rising edge
- rst_46  input  1  asynchronous active-high reset
- opcode_46  input  6  decoded opcode
- src_reg_46, dest_reg_46, targ_reg_46  input  RW  register indices, passed through
- src_val_46  input  DW  value of src register
- targ_val_46  input  DW  value of targ register
- imm_46  input  IW  immediate / branch offset
- pc_46  input  DW  address of this instruction
- flush_46  input  1  squash the instruction currently presented
- stall_46  output  1  upstream must hold its instruction
- br_taken_46  output  1  registered one-cycle taken-branch pulse
- br_target_46  output  DW  branch target, valid with br_taken_46
- opcode_out_46  output  6  to memory stage
- src_reg_out_46, dest_reg_out_46, targ_reg_out_46  output  RW  to memory stage
- alu_out_46  output  DW  ALU result / memory address
- alu_src_46  output  DW  store data (targ value)

Behaviour:
- Reset is asynchronous, active-high on rst_46. During and after reset:
  - opcode_out_46 = NOPE (6'b111111)
  - every other output = 0
  - FSM = IDLE, iteration counter = 0
  - a reset during MUL aborts it; no result is emitted.
- Opcodes:
  - ADD 110001, ADDI 000100, MUL 100111, LDW 010111, STW 010101
  - BLT 010110, BEQ 100110, BR 000110, NOPE 111111
- sext(imm) = imm_46 sign-extended to DW. All arithmetic wraps modulo 2^DW; no overflow flag.
- Single-cycle ops in IDLE, not flushed: outputs are registered on the next rising edge (latency 1).
  - ADD: alu_out = src + targ.
  - ADDI: alu_out = src + sext(imm).
  - LDW: alu_out = src + sext(imm).
  - STW: alu_out = src + sext(imm); alu_src = targ_val.
  - For all other ops, alu_src = targ_val.
  - BR: taken; target = pc + sext(imm).
  - BEQ: taken iff src == targ.
  - BLT: taken iff src < targ, signed compare.
  - For branches, alu_out = 0 and the opcode and register fields pass through.
  - NOPE and unknown opcodes: opcode passes through, alu_out = 0, no branch.
  - Register indices always pass through unchanged with their instruction.
- br_taken_46 is high for exactly the one cycle in which the branch instruction sits in the output register; otherwise 0. br_target_46 holds its last value when br_taken_46 is 0.
- flush_46 high at an edge: the presented instruction is discarded.
  - Output register loads NOPE with all fields 0.
  - No branch pulse; no MUL started.
  - flush_46 takes priority over MUL start.
- MUL FSM, states IDLE and BUSY:
  - IDLE with MUL presented, not flushed: at edge E0, latch multiplicand = src, multiplier = targ, product = 0, counter = 0, and the dest/src/targ indices. Go to BUSY. The output register loads a NOPE bubble.
  - BUSY: stall_46 = 1 (combinational from state). At each edge, if the multiplier LSB is 1, add the multiplicand to the product. Then shift the multiplicand left 1, shift the multiplier right 1, and increment the counter.
  - At the edge where counter == DW-1 (E32 for DW = 32): the output register loads opcode MUL, the latched indices, alu_out = low DW bits of the final product, and alu_src = latched targ. Return to IDLE.
  - The result is therefore visible 32 cycles after E0. Every output cycle from E0 through E31 is a NOPE bubble.
  - In BUSY, opcode_46, the operands and flush_46 are ignored; upstream holds its instruction and it is processed in the cycle after return to IDLE.
  - In IDLE, stall_46 = 0.
- MUL with a zero operand still takes the full DW iterations; there is no early exit.

Test Plan:
- Reset asserted mid-cycle, asynchronously -> all outputs 0 and opcode_out_46 = 111111 immediately, without waiting for a clock edge.
- ADD with src = 0xFFFFFFFF, targ = 2 -> next cycle alu_out = 0x00000001, opcode_out = 110001, indices echoed. Then ADDI with src = 10, imm = 0xFFFD -> alu_out = 7.
- STW with src = 0x100, imm = 8, targ = 0xDEADBEEF -> alu_out = 0x108, alu_src = 0xDEADBEEF.
- Branches at pc = 0x40, imm = 4:
  - BLT src = -1, targ = 1 -> br_taken = 1 for 1 cycle, br_target = 0x44.
  - BEQ with 5 vs 6 -> br_taken = 0.
  - BR with flush_46 = 1 -> NOPE out, no pulse.
- MUL src = 7, targ = 6, followed by ADD -> stall_46 high for exactly 32 cycles; NOPE bubbles out; alu_out = 42 with opcode MUL; then the ADD result follows one cycle later.
- MUL 0x10000 * 0x10000 -> alu_out = 0 (wrap). Separately, assert rst_46 at iteration 10 of a MUL -> FSM IDLE, stall_46 = 0, no MUL result ever emitted.

Source files
------------

// File: rtl/execute_stage_if.sv
// Decode-to-EX inputs and EX/MEM register outputs of the execute stage.
// The slave side is the stage itself; the master side is whatever drives decode.
interface execute_stage_if #(
    parameter int DW = 32,
    parameter int RW = 6,
    parameter int IW = 16
);
    logic [5:0]    opcode_46;
    logic [RW-1:0] src_reg_46;
    logic [RW-1:0] dest_reg_46;
    logic [RW-1:0] targ_reg_46;
    logic [DW-1:0] src_val_46;
    logic [DW-1:0] targ_val_46;
    logic [IW-1:0] imm_46;
    logic [DW-1:0] pc_46;
    logic          flush_46;
    logic          stall_46;
    logic          br_taken_46;
    logic [DW-1:0] br_target_46;
    logic [5:0]    opcode_out_46;
    logic [RW-1:0] src_reg_out_46;
    logic [RW-1:0] dest_reg_out_46;
    logic [RW-1:0] targ_reg_out_46;
    logic [DW-1:0] alu_out_46;
    logic [DW-1:0] alu_src_46;

    modport master (
        output opcode_46, src_reg_46, dest_reg_46, targ_reg_46, src_val_46,
               targ_val_46, imm_46, pc_46, flush_46,
        input  stall_46, br_taken_46, br_target_46, opcode_out_46, src_reg_out_46,
               dest_reg_out_46, targ_reg_out_46, alu_out_46, alu_src_46
    );

    modport slave (
        input  opcode_46, src_reg_46, dest_reg_46, targ_reg_46, src_val_46,
               targ_val_46, imm_46, pc_46, flush_46,
        output stall_46, br_taken_46, br_target_46, opcode_out_46, src_reg_out_46,
               dest_reg_out_46, targ_reg_out_46, alu_out_46, alu_src_46
    );
endinterface

// File: rtl/execute_stage.sv
// EX pipeline stage: single-cycle ALU/address/branch ops plus an iterative
// shift-add multiplier that stalls upstream for DW cycles.
//
// state | meaning
// IDLE  | accepting instructions; single-cycle ops retire next edge
// BUSY  | multiplying one bit per edge; stall high, bubbles emitted
module execute_stage #(
    parameter int DW = 32,
    parameter int RW = 6,
    parameter int IW = 16
) (
    input  logic           clk_46,
    input  logic           rst_46,
    execute_stage_if.slave bus
);
    localparam logic [5:0] OP_ADD  = 6'b110001;
    localparam logic [5:0] OP_ADDI = 6'b000100;
    localparam logic [5:0] OP_MUL  = 6'b100111;
    localparam logic [5:0] OP_LDW  = 6'b010111;
    localparam logic [5:0] OP_STW  = 6'b010101;
    localparam logic [5:0] OP_BLT  = 6'b010110;
    localparam logic [5:0] OP_BEQ  = 6'b100110;
    localparam logic [5:0] OP_BR   = 6'b000110;
    localparam logic [5:0] OP_NOPE = 6'b111111;
    localparam int         CW      = $clog2(DW);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t        state, state_nxt;
    logic          start_mul, mul_done;
    logic [DW-1:0] mcand, mplier, product, prod_step, mul_targ;
    logic [CW-1:0] cnt;
    logic [RW-1:0] mul_src_reg, mul_dest_reg, mul_targ_reg;
    logic [DW-1:0] imm_ext, alu_calc, br_calc;
    logic          take;

    assign imm_ext   = {{(DW-IW){bus.imm_46[IW-1]}}, bus.imm_46};
    assign br_calc   = bus.pc_46 + imm_ext;
    assign prod_step = product + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk_46 or posedge rst_46) begin
        if (rst_46) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        start_mul    = 1'b0;
        mul_done     = 1'b0;
        bus.stall_46 = 1'b0;
        case (state)
            IDLE: begin
                if (!bus.flush_46 && bus.opcode_46 == OP_MUL) begin
                    start_mul = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                bus.stall_46 = 1'b1;
                if (cnt == CW'(DW-1)) begin
                    mul_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        alu_calc = '0;
        take     = 1'b0;
        case (bus.opcode_46)
            OP_ADD:                 alu_calc = bus.src_val_46 + bus.targ_val_46;
            OP_ADDI, OP_LDW, OP_STW: alu_calc = bus.src_val_46 + imm_ext;
            OP_BR:                  take = 1'b1;
            OP_BEQ:                 take = (bus.src_val_46 == bus.targ_val_46);
            OP_BLT:                 take = ($signed(bus.src_val_46) < $signed(bus.targ_val_46));
            default:                ;
        endcase
    end

    always_ff @(posedge clk_46 or posedge rst_46) begin
        if (rst_46) begin
            mcand               <= '0;
            mplier              <= '0;
            product             <= '0;
            cnt                 <= '0;
            mul_targ            <= '0;
            mul_src_reg         <= '0;
            mul_dest_reg        <= '0;
            mul_targ_reg        <= '0;
            bus.opcode_out_46   <= OP_NOPE;
            bus.src_reg_out_46  <= '0;
            bus.dest_reg_out_46 <= '0;
            bus.targ_reg_out_46 <= '0;
            bus.alu_out_46      <= '0;
            bus.alu_src_46      <= '0;
            bus.br_taken_46     <= 1'b0;
            bus.br_target_46    <= '0;
        end else begin
            // Bubble by default; the branches below override it when something retires.
            bus.opcode_out_46   <= OP_NOPE;
            bus.src_reg_out_46  <= '0;
            bus.dest_reg_out_46 <= '0;
            bus.targ_reg_out_46 <= '0;
            bus.alu_out_46      <= '0;
            bus.alu_src_46      <= '0;
            bus.br_taken_46     <= 1'b0;
            if (state == BUSY) begin
                product <= prod_step;
                mcand   <= mcand << 1;
                mplier  <= mplier >> 1;
                cnt     <= cnt + CW'(1);
                if (mul_done) begin
                    bus.opcode_out_46   <= OP_MUL;
                    bus.src_reg_out_46  <= mul_src_reg;
                    bus.dest_reg_out_46 <= mul_dest_reg;
                    bus.targ_reg_out_46 <= mul_targ_reg;
                    bus.alu_out_46      <= prod_step;
                    bus.alu_src_46      <= mul_targ;
                end
            end else if (!bus.flush_46) begin
                if (start_mul) begin
                    mcand        <= bus.src_val_46;
                    mplier       <= bus.targ_val_46;
                    product      <= '0;
                    cnt          <= '0;
                    mul_targ     <= bus.targ_val_46;
                    mul_src_reg  <= bus.src_reg_46;
                    mul_dest_reg <= bus.dest_reg_46;
                    mul_targ_reg <= bus.targ_reg_46;
                end else begin
                    bus.opcode_out_46   <= bus.opcode_46;
                    bus.src_reg_out_46  <= bus.src_reg_46;
                    bus.dest_reg_out_46 <= bus.dest_reg_46;
                    bus.targ_reg_out_46 <= bus.targ_reg_46;
                    bus.alu_out_46      <= alu_calc;
                    bus.alu_src_46      <= bus.targ_val_46;
                    bus.br_taken_46     <= take;
                    if (take) bus.br_target_46 <= br_calc;
                end
            end
        end
    end
endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed table, multi-cycle MUL and
// reset sequences, then random instructions against a behavioural model.
module tb_execute_stage;
    localparam logic [5:0] OP_ADD  = 6'b110001;
    localparam logic [5:0] OP_ADDI = 6'b000100;
    localparam logic [5:0] OP_MUL  = 6'b100111;
    localparam logic [5:0] OP_LDW  = 6'b010111;
    localparam logic [5:0] OP_STW  = 6'b010101;
    localparam logic [5:0] OP_BLT  = 6'b010110;
    localparam logic [5:0] OP_BEQ  = 6'b100110;
    localparam logic [5:0] OP_BR   = 6'b000110;
    localparam logic [5:0] OP_NOPE = 6'b111111;

    typedef struct packed {
        logic [5:0]  op;
        logic [31:0] src;
        logic [31:0] targ;
        logic [15:0] imm;
        logic [31:0] pc;
        logic        flush;
        logic [5:0]  sreg, dreg, treg;
    } in_t;

    typedef struct packed {
        logic [5:0]  op;
        logic [5:0]  sreg, dreg, treg;
        logic [31:0] alu, asrc;
        logic        br;
        logic [31:0] tgt;
        logic        stall;
    } exp_t;

    typedef struct packed {
        in_t  in;
        exp_t ex;
    } vec_t;

    logic clk, rst;
    int   errs = 0;
    int   checks = 0;
    logic [31:0] exp_tgt;
    vec_t tbl [13];

    execute_stage_if bus ();
    execute_stage dut (.clk_46(clk), .rst_46(rst), .bus(bus));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, expv);
        end
    endtask

    task automatic check_all(input string nm, input exp_t e);
        chk({nm, ".opcode"}, 32'(bus.opcode_out_46), 32'(e.op));
        chk({nm, ".src_reg"}, 32'(bus.src_reg_out_46), 32'(e.sreg));
        chk({nm, ".dest_reg"}, 32'(bus.dest_reg_out_46), 32'(e.dreg));
        chk({nm, ".targ_reg"}, 32'(bus.targ_reg_out_46), 32'(e.treg));
        chk({nm, ".alu_out"}, bus.alu_out_46, e.alu);
        chk({nm, ".alu_src"}, bus.alu_src_46, e.asrc);
        chk({nm, ".br_taken"}, 32'(bus.br_taken_46), 32'(e.br));
        chk({nm, ".br_target"}, bus.br_target_46, e.tgt);
        chk({nm, ".stall"}, 32'(bus.stall_46), 32'(e.stall));
    endtask

    function automatic in_t mk_in(input logic [5:0] op, input logic [31:0] src,
                                  input logic [31:0] targ, input logic [15:0] imm,
                                  input logic [31:0] pc, input logic flush, input int idx);
        in_t i;
        i.op = op; i.src = src; i.targ = targ; i.imm = imm; i.pc = pc; i.flush = flush;
        i.sreg = 6'(idx); i.dreg = 6'(idx + 1); i.treg = 6'(idx + 2);
        return i;
    endfunction

    function automatic exp_t mk_ex(input in_t i, input logic [5:0] op, input logic [31:0] alu,
                                   input logic [31:0] asrc, input logic br, input logic [31:0] tgt);
        exp_t e;
        e.op = op; e.alu = alu; e.asrc = asrc; e.br = br; e.tgt = tgt; e.stall = 1'b0;
        e.sreg = i.flush ? 6'd0 : i.sreg;
        e.dreg = i.flush ? 6'd0 : i.dreg;
        e.treg = i.flush ? 6'd0 : i.treg;
        return e;
    endfunction

    // Behavioural model of one single-cycle instruction (MUL is handled by run_mul).
    function automatic exp_t model(input in_t i, input logic [31:0] ptgt);
        exp_t e;
        logic [31:0] sx;
        sx = {{16{i.imm[15]}}, i.imm};
        e = '0;
        e.op = OP_NOPE;
        e.tgt = ptgt;
        if (!i.flush) begin
            e.op = i.op; e.sreg = i.sreg; e.dreg = i.dreg; e.treg = i.treg;
            e.asrc = i.targ;
            case (i.op)
                OP_ADD:                  e.alu = i.src + i.targ;
                OP_ADDI, OP_LDW, OP_STW: e.alu = i.src + sx;
                OP_BR:                   e.br = 1'b1;
                OP_BEQ:                  e.br = (i.src == i.targ);
                OP_BLT:                  e.br = ($signed(i.src) < $signed(i.targ));
                default:                 ;
            endcase
            if (e.br) e.tgt = i.pc + sx;
        end
        return e;
    endfunction

    function automatic in_t rnd(input bit allow_mul);
        in_t i;
        logic [5:0] unk [4];
        unk[0] = 6'h00; unk[1] = 6'h01; unk[2] = 6'h3E; unk[3] = 6'h20;
        case ($urandom_range(0, 9))
            0: i.op = OP_ADD;
            1: i.op = OP_ADDI;
            2: i.op = allow_mul ? OP_MUL : OP_LDW;
            3: i.op = OP_LDW;
            4: i.op = OP_STW;
            5: i.op = OP_BLT;
            6: i.op = OP_BEQ;
            7: i.op = OP_BR;
            8: i.op = OP_NOPE;
            default: i.op = unk[$urandom_range(0, 3)];
        endcase
        i.src   = $urandom;
        i.targ  = ($urandom_range(0, 3) == 0) ? i.src : $urandom;
        i.imm   = 16'($urandom);
        i.pc    = $urandom;
        i.flush = ($urandom_range(0, 9) == 0);
        i.sreg  = 6'($urandom); i.dreg = 6'($urandom); i.treg = 6'($urandom);
        return i;
    endfunction

    task automatic present(input in_t i);
        bus.opcode_46   = i.op;
        bus.src_val_46  = i.src;
        bus.targ_val_46 = i.targ;
        bus.imm_46      = i.imm;
        bus.pc_46       = i.pc;
        bus.flush_46    = i.flush;
        bus.src_reg_46  = i.sreg;
        bus.dest_reg_46 = i.dreg;
        bus.targ_reg_46 = i.treg;
    endtask

    task automatic step(input in_t i, input string nm);
        exp_t e;
        present(i);
        @(posedge clk); #1;
        e = model(i, exp_tgt);
        check_all(nm, e);
        exp_tgt = e.tgt;
    endtask

    task automatic check_reset(input string nm);
        exp_t e;
        e = '0;
        e.op = OP_NOPE;
        exp_tgt = 32'd0;
        check_all(nm, e);
    endtask

    // MUL, then the instruction upstream holds while stalled, retired after the product.
    task automatic run_mul(input in_t m, input in_t held, input string nm);
        exp_t e;
        int   n_stall;
        present(m);
        @(posedge clk); #1;
        e = '0;
        e.op = OP_NOPE; e.tgt = exp_tgt; e.stall = 1'b1;
        check_all({nm, ".e0"}, e);
        present(held);
        n_stall = 1;
        for (int k = 0; k < 40 && bus.stall_46 === 1'b1; k++) begin
            @(posedge clk); #1;
            if (bus.stall_46 === 1'b1) begin
                n_stall++;
                chk({nm, ".bubble"}, 32'(bus.opcode_out_46), 32'(OP_NOPE));
            end
        end
        chk({nm, ".stall_cycles"}, 32'(n_stall), 32'd32);
        e.op = OP_MUL; e.sreg = m.sreg; e.dreg = m.dreg; e.treg = m.treg;
        e.alu = m.src * m.targ; e.asrc = m.targ; e.br = 1'b0; e.stall = 1'b0;
        check_all({nm, ".result"}, e);
        step(held, {nm, ".held"});
    endtask

    initial begin
        in_t i, n;
        rst = 1'b0;
        exp_tgt = 32'd0;
        present(mk_in(OP_NOPE, 0, 0, 0, 0, 1'b0, 0));

        tbl[0].in  = mk_in(OP_ADD,  32'hFFFFFFFF, 32'd2,        16'h0000, 32'h0,   1'b0, 0);
        tbl[0].ex  = mk_ex(tbl[0].in,  OP_ADD,  32'd1,     32'd2,        1'b0, 32'h0);
        tbl[1].in  = mk_in(OP_ADDI, 32'd10,       32'd0,        16'hFFFD, 32'h0,   1'b0, 1);
        tbl[1].ex  = mk_ex(tbl[1].in,  OP_ADDI, 32'd7,     32'd0,        1'b0, 32'h0);
        tbl[2].in  = mk_in(OP_STW,  32'h100,      32'hDEADBEEF, 16'h0008, 32'h0,   1'b0, 2);
        tbl[2].ex  = mk_ex(tbl[2].in,  OP_STW,  32'h108,   32'hDEADBEEF, 1'b0, 32'h0);
        tbl[3].in  = mk_in(OP_LDW,  32'h1000,     32'd5,        16'hFFF0, 32'h0,   1'b0, 3);
        tbl[3].ex  = mk_ex(tbl[3].in,  OP_LDW,  32'hFF0,   32'd5,        1'b0, 32'h0);
        tbl[4].in  = mk_in(OP_BLT,  32'hFFFFFFFF, 32'd1,        16'h0004, 32'h40,  1'b0, 4);
        tbl[4].ex  = mk_ex(tbl[4].in,  OP_BLT,  32'd0,     32'd1,        1'b1, 32'h44);
        tbl[5].in  = mk_in(OP_BEQ,  32'd5,        32'd6,        16'h0004, 32'h40,  1'b0, 5);
        tbl[5].ex  = mk_ex(tbl[5].in,  OP_BEQ,  32'd0,     32'd6,        1'b0, 32'h44);
        tbl[6].in  = mk_in(OP_BR,   32'd1,        32'd2,        16'h0004, 32'h40,  1'b1, 6);
        tbl[6].ex  = mk_ex(tbl[6].in,  OP_NOPE, 32'd0,     32'd0,        1'b0, 32'h44);
        tbl[7].in  = mk_in(OP_BEQ,  32'd9,        32'd9,        16'hFFFC, 32'h100, 1'b0, 7);
        tbl[7].ex  = mk_ex(tbl[7].in,  OP_BEQ,  32'd0,     32'd9,        1'b1, 32'hFC);
        tbl[8].in  = mk_in(OP_BR,   32'd0,        32'd3,        16'h0010, 32'h200, 1'b0, 8);
        tbl[8].ex  = mk_ex(tbl[8].in,  OP_BR,   32'd0,     32'd3,        1'b1, 32'h210);
        tbl[9].in  = mk_in(OP_NOPE, 32'd8,        32'd7,        16'h0000, 32'h0,   1'b0, 9);
        tbl[9].ex  = mk_ex(tbl[9].in,  OP_NOPE, 32'd0,     32'd7,        1'b0, 32'h210);
        tbl[10].in = mk_in(6'h00,   32'd5,        32'd9,        16'h0001, 32'h0,   1'b0, 10);
        tbl[10].ex = mk_ex(tbl[10].in, 6'h00,   32'd0,     32'd9,        1'b0, 32'h210);
        tbl[11].in = mk_in(OP_BLT,  32'd1,        32'hFFFFFFFF, 16'h0004, 32'h40,  1'b0, 11);
        tbl[11].ex = mk_ex(tbl[11].in, OP_BLT,  32'd0,     32'hFFFFFFFF, 1'b0, 32'h210);
        tbl[12].in = mk_in(OP_ADD,  32'd1,        32'd1,        16'h0000, 32'h0,   1'b1, 12);
        tbl[12].ex = mk_ex(tbl[12].in, OP_NOPE, 32'd0,     32'd0,        1'b0, 32'h210);

        #2 rst = 1'b1;
        #1 check_reset("reset_init");
        #3 rst = 1'b0;

        for (int k = 0; k < 13; k++) begin
            present(tbl[k].in);
            @(posedge clk); #1;
            check_all($sformatf("vec%0d", k), tbl[k].ex);
        end
        exp_tgt = 32'h210;

        // Reset in the middle of a cycle must clear outputs without an edge.
        step(mk_in(OP_BR, 32'd3, 32'd4, 16'h0008, 32'h80, 1'b0, 20), "pre_async");
        #2 rst = 1'b1;
        #1 check_reset("async_reset");
        #2 rst = 1'b0;

        run_mul(mk_in(OP_MUL, 32'd7, 32'd6, 16'h0, 32'h0, 1'b0, 30),
                mk_in(OP_ADD, 32'd3, 32'd4, 16'h0, 32'h0, 1'b0, 33), "mul_7x6");
        run_mul(mk_in(OP_MUL, 32'h10000, 32'h10000, 16'h0, 32'h0, 1'b0, 40),
                mk_in(OP_NOPE, 32'd0, 32'd1, 16'h0, 32'h0, 1'b0, 43), "mul_wrap");
        run_mul(mk_in(OP_MUL, 32'd0, 32'h1234, 16'h0, 32'h0, 1'b0, 50),
                mk_in(OP_BEQ, 32'd2, 32'd2, 16'h0002, 32'h500, 1'b0, 53), "mul_zero");

        // Reset at iteration 10 of a MUL: no product may ever appear.
        present(mk_in(OP_MUL, 32'd11, 32'd13, 16'h0, 32'h0, 1'b0, 60));
        @(posedge clk); #1;
        n = mk_in(OP_NOPE, 32'd0, 32'd0, 16'h0, 32'h0, 1'b0, 0);
        present(n);
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1 check_reset("mul_abort");
        #2 rst = 1'b0;
        for (int k = 0; k < 40; k++) step(n, "post_abort");

        for (int k = 0; k < 250; k++) begin
            i = rnd(1'b1);
            if (i.op == OP_MUL && !i.flush) run_mul(i, rnd(1'b0), "rand_mul");
            else                            step(i, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
